pool_window_gen: RTL and testbench

Streaming 2x2 window former that sits directly upstream of the 2x2 max-pool stage in the VGG16 datapath. It accepts one feature-map pixel per valid cycle in raster order. It buffers one even row and emits each non-overlapping 2x2 window (stride 2) as four parallel words with the two enables the pool stage consumes. One window is emitted per two pixels of every odd row, giving (IMG_WIDTH/2)*(IMG_HEIGHT/2) windows per frame.

---
 rtl/pool_window_gen_if.sv | 70 +++++++
 rtl/pool_window_gen.sv | 197 +++++++++++++++++++
 tb/tb_pool_window_gen.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pool_window_gen_if.sv
// -----------------------------------------------------------------------------
// pool_window_gen_if
//
// Purpose : Bundles the pixel input stream and the 2x2 window output of
//           pool_window_gen so that upstream and downstream logic connect
//           through one port.
//
// Signals :
//   i_valid      pixel on i_data is valid this cycle
//   i_data       pixel word, raster order
//   i_sof        start of frame, qualified by i_valid
//                (present only when POOL_WIN_SOF_EN is defined)
//   o_a, o_b     window top-left / top-right
//   o_c, o_d     window bottom-left / bottom-right
//   o_valid      window on o_a..o_d is new (pool stage-1 enable)
//   o_valid1     o_valid delayed by one cycle (pool stage-2 enable)
//   o_frame_done pulse with the last window of a frame
//
// Modports:
//   master : the side that produces pixels and consumes windows
//   slave  : the window former itself
//
// Optional feature macro: POOL_WIN_SOF_EN adds the i_sof signal.
// -----------------------------------------------------------------------------
interface pool_window_gen_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  i_valid;
    logic [DATA_WIDTH-1:0] i_data;
`ifdef POOL_WIN_SOF_EN
    logic                  i_sof;
`endif
    logic [DATA_WIDTH-1:0] o_a;
    logic [DATA_WIDTH-1:0] o_b;
    logic [DATA_WIDTH-1:0] o_c;
    logic [DATA_WIDTH-1:0] o_d;
    logic                  o_valid;
    logic                  o_valid1;
    logic                  o_frame_done;

    modport master (
        output i_valid,
        output i_data,
`ifdef POOL_WIN_SOF_EN
        output i_sof,
`endif
        input  o_a,
        input  o_b,
        input  o_c,
        input  o_d,
        input  o_valid,
        input  o_valid1,
        input  o_frame_done
    );

    modport slave (
        input  i_valid,
        input  i_data,
`ifdef POOL_WIN_SOF_EN
        input  i_sof,
`endif
        output o_a,
        output o_b,
        output o_c,
        output o_d,
        output o_valid,
        output o_valid1,
        output o_frame_done
    );
endinterface

// File: rtl/pool_window_gen.sv
// -----------------------------------------------------------------------------
// pool_window_gen
//
// Purpose : Streaming 2x2 stride-2 window former feeding the 2x2 max-pool
//           stage. Pixels arrive one per valid cycle in raster order. Every
//           even row is stored in a one-row line buffer; on the following odd
//           row each pair of pixels is combined with the two buffered pixels
//           above them to form one window.
//
// Parameters:
//   DATA_WIDTH  pixel word width
//   IMG_WIDTH   pixels per row  (even, >= 2)
//   IMG_HEIGHT  rows per frame  (even, >= 2)
//
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-high reset
//   bus   pool_window_gen_if.slave (pixel stream in, window out)
//
// Optional feature macro: POOL_WIN_SOF_EN
//   defined   : bus.i_sof exists; a valid pixel with i_sof is forced to
//               row 0 / col 0, abandoning any partially built window.
//   undefined : framing comes purely from the free-running counters.
// -----------------------------------------------------------------------------
module pool_window_gen #(
    parameter int DATA_WIDTH = 32,
    parameter int IMG_WIDTH  = 224,
    parameter int IMG_HEIGHT = 224
) (
    input  logic              clk,
    input  logic              rst,
    pool_window_gen_if.slave  bus
);

    localparam int COL_W = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
    localparam int ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);
    localparam int NUM_LANES = 4;

    // Odd dimensions would leave a half window at the edge of every row or
    // frame, which the pool stage cannot consume.
    generate
        if ((IMG_WIDTH % 2) != 0 || IMG_WIDTH < 2) begin : g_bad_width
            $error("pool_window_gen: IMG_WIDTH must be even and >= 2");
        end
        if ((IMG_HEIGHT % 2) != 0 || IMG_HEIGHT < 2) begin : g_bad_height
            $error("pool_window_gen: IMG_HEIGHT must be even and >= 2");
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Position counters
    // -------------------------------------------------------------------------
    logic [COL_W-1:0] col_reg;
    logic [COL_W-1:0] col_next;
    logic [ROW_W-1:0] row_reg;
    logic [ROW_W-1:0] row_next;

    // Position of the pixel currently on the bus. A start-of-frame pixel
    // overrides the counters so framing recovers within one pixel.
    logic [COL_W-1:0] cur_col;
    logic [ROW_W-1:0] cur_row;
    logic             sof_hit;

`ifdef POOL_WIN_SOF_EN
    assign sof_hit = bus.i_valid && bus.i_sof;
`else
    assign sof_hit = 1'b0;
`endif

    assign cur_col = sof_hit ? '0 : col_reg;
    assign cur_row = sof_hit ? '0 : row_reg;

    always_comb begin
        col_next = col_reg;
        row_next = row_reg;
        if (bus.i_valid) begin
            if (cur_col == COL_LAST) begin
                col_next = '0;
                row_next = (cur_row == ROW_LAST) ? '0 : cur_row + ROW_W'(1);
            end else begin
                col_next = cur_col + COL_W'(1);
                row_next = cur_row;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_reg <= '0;
            row_reg <= '0;
        end else begin
            col_reg <= col_next;
            row_reg <= row_next;
        end
    end

    // -------------------------------------------------------------------------
    // Per-pixel actions
    // -------------------------------------------------------------------------
    logic wr_en;      // even row: store pixel for the row below
    logic hold_en;    // odd row, even col: left half of the window
    logic win_en;     // odd row, odd col: window complete
    logic last_win;   // window that closes the frame

    assign wr_en    = bus.i_valid && !cur_row[0];
    assign hold_en  = bus.i_valid &&  cur_row[0] && !cur_col[0];
    assign win_en   = bus.i_valid &&  cur_row[0] &&  cur_col[0];
    assign last_win = win_en && (cur_row == ROW_LAST) && (cur_col == COL_LAST);

    // -------------------------------------------------------------------------
    // Line buffer: one even row. Writes happen only on even rows and reads only
    // on odd rows, so the same address is never read and written together.
    // Contents are deliberately left unreset.
    // -------------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] linebuf [IMG_WIDTH];
    logic [DATA_WIDTH-1:0] rd_word;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            linebuf[cur_col] <= bus.i_data;
        end
    end

    assign rd_word = linebuf[cur_col];

    // -------------------------------------------------------------------------
    // Left-half holding registers (the linebuf read lands here directly)
    // -------------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] hold_a_reg;
    logic [DATA_WIDTH-1:0] hold_c_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_a_reg <= '0;
            hold_c_reg <= '0;
        end else if (hold_en) begin
            hold_a_reg <= rd_word;
            hold_c_reg <= bus.i_data;
        end
    end

    // -------------------------------------------------------------------------
    // Window output lanes: 0=a (top-left), 1=b (top-right),
    // 2=c (bottom-left), 3=d (bottom-right). They keep their value until the
    // next window so the pool stage may sample them late.
    // -------------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] lane_src [NUM_LANES];
    logic [DATA_WIDTH-1:0] win_reg  [NUM_LANES];

    assign lane_src[0] = hold_a_reg;
    assign lane_src[1] = rd_word;
    assign lane_src[2] = hold_c_reg;
    assign lane_src[3] = bus.i_data;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    win_reg[gi] <= '0;
                end else if (win_en) begin
                    win_reg[gi] <= lane_src[gi];
                end
            end
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Enables for the two pool stages and the frame marker
    // -------------------------------------------------------------------------
    logic valid_reg;
    logic valid1_reg;
    logic frame_done_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_reg      <= 1'b0;
            valid1_reg     <= 1'b0;
            frame_done_reg <= 1'b0;
        end else begin
            valid_reg      <= win_en;
            valid1_reg     <= valid_reg;
            frame_done_reg <= last_win;
        end
    end

    assign bus.o_a          = win_reg[0];
    assign bus.o_b          = win_reg[1];
    assign bus.o_c          = win_reg[2];
    assign bus.o_d          = win_reg[3];
    assign bus.o_valid      = valid_reg;
    assign bus.o_valid1     = valid1_reg;
    assign bus.o_frame_done = frame_done_reg;

endmodule

// File: tb/tb_pool_window_gen.sv
// -----------------------------------------------------------------------------
// tb_pool_window_gen
//
// Two instances: a 4x4 one for the directed framing scenarios and a 224x224
// one streaming a full random frame. Expected windows come from a model that
// stores each frame as a flat image and picks the four pixels of a window by
// index arithmetic whenever a bottom-right pixel is accepted.
// -----------------------------------------------------------------------------
module tb_pool_window_gen;

    localparam int DW = 32;
    localparam int SW = 4;
    localparam int SH = 4;
    localparam int LW = 224;
    localparam int LH = 224;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pool_window_gen_if #(.DATA_WIDTH(DW)) bus_s ();
    pool_window_gen_if #(.DATA_WIDTH(DW)) bus_l ();

    pool_window_gen #(.DATA_WIDTH(DW), .IMG_WIDTH(SW), .IMG_HEIGHT(SH)) dut_s (
        .clk (clk),
        .rst (rst),
        .bus (bus_s)
    );

    pool_window_gen #(.DATA_WIDTH(DW), .IMG_WIDTH(LW), .IMG_HEIGHT(LH)) dut_l (
        .clk (clk),
        .rst (rst),
        .bus (bus_l)
    );

    typedef struct {
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [DW-1:0] c;
        logic [DW-1:0] d;
        logic          done;
        int            due;
    } win_t;

    win_t          exp_q [2][$];
    int            img_w [2] = '{SW, LW};
    int            img_h [2] = '{SH, LH};
    int            pix   [2];
    logic [DW-1:0] img   [2][LW*LH];
    int            win_seen   [2];
    int            win_pushed [2];
    int            done_seen  [2];
    int            done_pushed[2];
    logic          prev_v     [2];
    int            neg_cnt;
    int            n_checks;
    int            n_pass;

    task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Reference: pixel index p within the frame gives row p/W, col p%W. A
    // window completes on every odd-row, odd-col pixel; its other three pixels
    // sit at p-1, p-W and p-W-1 in the stored image.
    task automatic model_accept(input int k, input logic [DW-1:0] d, input bit sof);
        int p;
        int r;
        int c;
        win_t e;
        if (sof) pix[k] = 0;
        p = pix[k];
        r = p / img_w[k];
        c = p % img_w[k];
        img[k][p] = d;
        if ((r % 2 == 1) && (c % 2 == 1)) begin
            e.a    = img[k][p - img_w[k] - 1];
            e.b    = img[k][p - img_w[k]];
            e.c    = img[k][p - 1];
            e.d    = d;
            e.done = (p == img_w[k] * img_h[k] - 1);
            e.due  = neg_cnt + 1;
            exp_q[k].push_back(e);
            win_pushed[k]++;
            if (e.done) done_pushed[k]++;
        end
        pix[k] = (p + 1) % (img_w[k] * img_h[k]);
    endtask

    task automatic drive(input int k, input logic v, input logic [DW-1:0] d);
        if (k == 0) begin
            bus_s.i_valid = v;
            bus_s.i_data  = d;
        end else begin
            bus_l.i_valid = v;
            bus_l.i_data  = d;
        end
    endtask

    task automatic set_sof(input int k, input bit s);
`ifdef POOL_WIN_SOF_EN
        if (k == 0) bus_s.i_sof = s;
        else        bus_l.i_sof = s;
`else
        if (s && k < 0) $display("no start-of-frame input in this build");
`endif
    endtask

    // One accepted pixel; inputs change 1 time unit after the edge.
    task automatic send(input int k, input logic [DW-1:0] d, input bit sof);
        drive(k, 1'b1, d);
        set_sof(k, sof);
        @(posedge clk);
        model_accept(k, d, sof);
        #1;
        drive(k, 1'b0, DW'($urandom));
        set_sof(k, 1'b0);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            bus_s.i_data = DW'($urandom);
            bus_l.i_data = DW'($urandom);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            exp_q[k].delete();
            pix[k] = 0;
        end
        repeat (2) @(posedge clk);
        #1;
        check_value("rst_o_a",          64'(bus_s.o_a),          64'd0);
        check_value("rst_o_b",          64'(bus_s.o_b),          64'd0);
        check_value("rst_o_c",          64'(bus_s.o_c),          64'd0);
        check_value("rst_o_d",          64'(bus_s.o_d),          64'd0);
        check_value("rst_o_valid",      64'(bus_s.o_valid),      64'd0);
        check_value("rst_o_valid1",     64'(bus_s.o_valid1),     64'd0);
        check_value("rst_o_frame_done", 64'(bus_s.o_frame_done), 64'd0);
        rst = 1'b0;
    endtask

    task automatic mon(input int k, input logic v, input logic v1,
                       input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input logic [DW-1:0] c, input logic [DW-1:0] d,
                       input logic fd);
        win_t e;
        check_value($sformatf("o_valid1_dut%0d", k), 64'(v1), 64'(prev_v[k]));
        prev_v[k] = v;
        if (v) begin
            if (exp_q[k].size() == 0) begin
                check_value($sformatf("unexpected_o_valid_dut%0d", k), 64'(v), 64'd0);
            end else begin
                e = exp_q[k].pop_front();
                check_value($sformatf("o_a_dut%0d", k), 64'(a), 64'(e.a));
                check_value($sformatf("o_b_dut%0d", k), 64'(b), 64'(e.b));
                check_value($sformatf("o_c_dut%0d", k), 64'(c), 64'(e.c));
                check_value($sformatf("o_d_dut%0d", k), 64'(d), 64'(e.d));
                check_value($sformatf("frame_done_dut%0d", k), 64'(fd), 64'(e.done));
                check_value($sformatf("latency_dut%0d", k), 64'(neg_cnt), 64'(e.due));
                win_seen[k]++;
                if (fd) done_seen[k]++;
                if (k == 0)
                    $display("window: a=%0d b=%0d c=%0d d=%0d frame_done=%0b", a, b, c, d, fd);
            end
        end
    endtask

    always @(negedge clk) begin
        neg_cnt++;
        if (rst) begin
            prev_v[0] = 1'b0;
            prev_v[1] = 1'b0;
        end else begin
            mon(0, bus_s.o_valid, bus_s.o_valid1, bus_s.o_a, bus_s.o_b,
                bus_s.o_c, bus_s.o_d, bus_s.o_frame_done);
            mon(1, bus_l.o_valid, bus_l.o_valid1, bus_l.o_a, bus_l.o_b,
                bus_l.o_c, bus_l.o_d, bus_l.o_frame_done);
        end
    end

    initial begin
        drive(0, 1'b0, '0);
        drive(1, 1'b0, '0);
        set_sof(0, 1'b0);
        set_sof(1, 1'b0);
        #1;
        do_reset();

        // Continuous 4x4 frame
        for (int i = 0; i < 16; i++) send(0, DW'(i), 1'b0);
        idle(3);

        // Same frame with random gaps (garbage data while idle)
        for (int i = 0; i < 16; i++) begin
            send(0, DW'(i), 1'b0);
            idle($urandom_range(0, 3));
        end
        idle(3);

        // Two back-to-back frames, no dead cycle
        for (int i = 0; i < 16; i++) send(0, DW'(i), 1'b0);
        for (int i = 0; i < 16; i++) send(0, DW'(100 + i), 1'b0);
        idle(3);

        // Reset partway through a frame, before its first window completes
        for (int i = 0; i < 5; i++) send(0, DW'(i), 1'b0);
        do_reset();
        for (int i = 0; i < 16; i++) send(0, DW'(i), 1'b0);
        idle(3);

`ifdef POOL_WIN_SOF_EN
        // Truncated frame, then a start-of-frame pixel restarts framing
        for (int i = 0; i < 10; i++) send(0, DW'(i), 1'b0);
        for (int i = 0; i < 16; i++) send(0, DW'(i), (i == 0));
        idle(3);
`endif

        // Full-size frame of random pixels with occasional gaps
        for (int p = 0; p < LW * LH; p++) begin
            send(1, DW'($urandom), 1'b0);
            if ($urandom_range(0, 15) == 0) idle(1);
        end
        idle(4);

        check_value("pending_windows_dut0", 64'(exp_q[0].size()), 64'd0);
        check_value("pending_windows_dut1", 64'(exp_q[1].size()), 64'd0);
        check_value("window_count_dut0",    64'(win_seen[0]),     64'(win_pushed[0]));
        check_value("window_count_dut1",    64'(win_seen[1]),     64'((LW / 2) * (LH / 2)));
        check_value("frame_done_count_dut0", 64'(done_seen[0]),   64'(done_pushed[0]));
        check_value("frame_done_count_dut1", 64'(done_seen[1]),   64'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
